fp_norm_exp_adj: RTL and testbench

- Post-addition normaliser for the double-precision FP adder; the inverse of the pre-add exponent-subtract/align step.
- Takes the raw significand sum and the pre-add result exponent (the larger operand exponent).
- Removes carry-out or leading zeros, adjusts the exponent to match, and flags overflow, underflow (tiny) and zero.
- Two-stage pipeline with valid/ready handshake; feeds the rounder.

---
 rtl/fp_pkg.sv | 14 +
 rtl/fp_lzc.sv | 28 ++
 rtl/fp_norm_exp_adj.sv | 158 +++++++++++++++
 tb/tb_fp_norm_exp_adj.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fp_pkg.sv
// Shared constants and types for the double-precision adder datapath.
package fp_pkg;

    localparam int EXP_W      = 11;
    localparam int SIG_W      = 57;
    localparam int EXP_MAX    = 2047;
    localparam int CARRY_BIT  = 56;
    localparam int HIDDEN_BIT = 55;
    localparam int GRS_LSB    = 0;

    typedef logic [EXP_W-1:0] exp_t;
    typedef logic [SIG_W-1:0] sig_t;

endpackage

// File: rtl/fp_lzc.sv
// Combinational leading-zero counter with an all-zero flag.
module fp_lzc #(
    parameter int W  = 56,
    parameter int CW = $clog2(W + 1)
) (
    input  logic [W-1:0]  value,
    output logic [CW-1:0] count,
    output logic          all_zero
);

    // seen[i] is set when any bit at position i or above is a one
    logic [W-1:0] seen;

    for (genvar gi = 0; gi < W; gi++) begin : g_seen
        assign seen[gi] = |value[W-1:gi];
    end

    // Leading zeros equal the number of positions with no one at or above them
    always_comb begin
        count = '0;
        for (int i = 0; i < W; i++) begin
            count = count + {{(CW-1){1'b0}}, ~seen[i]};
        end
    end

    assign all_zero = ~seen[0];

endmodule

// File: rtl/fp_norm_exp_adj.sv
// Post-addition normaliser: strips carry-out or leading zeros from the raw
// significand sum, adjusts the exponent and flags overflow, tiny and zero.
// Two register stages with a valid/ready handshake.
module fp_norm_exp_adj #(
    parameter int EXP_W = fp_pkg::EXP_W,
    parameter int SIG_W = fp_pkg::SIG_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [EXP_W-1:0] in_exp,
    input  logic [SIG_W-1:0] in_sig,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [EXP_W-1:0] out_exp,
    output logic [SIG_W-1:0] out_sig,
    output logic             out_ovf,
    output logic             out_tiny,
    output logic             out_zero
);

    localparam int LZ_W = $clog2(SIG_W);
    localparam logic [EXP_W:0] EXP_TOP = {1'b0, {EXP_W{1'b1}}};

    // Handshake
    logic adv1;
    logic adv2;

    // Stage 1 registers
    logic             v1_reg;
    logic [EXP_W-1:0] exp1_reg;
    logic [SIG_W-1:0] sig1_reg;
    logic             carry1_reg;
    logic             zero1_reg;
    logic [LZ_W-1:0]  lzc1_reg;

    // Stage 1 combinational
    logic [LZ_W-1:0]  lzc_next;
    logic             low_zero;

    // Stage 2 registers and next values
    logic             v2_reg;
    logic [EXP_W-1:0] exp2_reg,  exp2_next;
    logic [SIG_W-1:0] sig2_reg,  sig2_next;
    logic             ovf2_reg,  ovf2_next;
    logic             tiny2_reg, tiny2_next;
    logic             zero2_reg, zero2_next;

    // Stage 2 helpers
    logic [EXP_W:0]   exp_ext;
    logic [EXP_W:0]   exp_inc;
    logic [EXP_W:0]   lzc_ext;
    logic [LZ_W-1:0]  tiny_shift;

    assign adv2     = ~v2_reg | out_ready;
    assign adv1     = ~v1_reg | adv2;
    assign in_ready = adv1;

    // Leading-zero count over hidden bit and below; the carry bit is handled separately
    fp_lzc #(
        .W  (SIG_W - 1),
        .CW (LZ_W)
    ) u_lzc (
        .value    (in_sig[SIG_W-2:0]),
        .count    (lzc_next),
        .all_zero (low_zero)
    );

    // Stage 1: capture operand and its classification
    always_ff @(posedge clk) begin
        if (rst) begin
            v1_reg     <= 1'b0;
            exp1_reg   <= '0;
            sig1_reg   <= '0;
            carry1_reg <= 1'b0;
            zero1_reg  <= 1'b0;
            lzc1_reg   <= '0;
        end else if (adv1) begin
            v1_reg <= in_valid;
            if (in_valid) begin
                exp1_reg   <= in_exp;
                sig1_reg   <= in_sig;
                carry1_reg <= in_sig[SIG_W-1];
                zero1_reg  <= low_zero & ~in_sig[SIG_W-1];
                lzc1_reg   <= lzc_next;
            end
        end
    end

    assign exp_ext    = {1'b0, exp1_reg};
    assign exp_inc    = exp_ext + 1'b1;
    assign lzc_ext    = {{(EXP_W+1-LZ_W){1'b0}}, lzc1_reg};
    // Only used when lzc >= exp, so exp - 1 < lzc and always fits the shifter
    assign tiny_shift = LZ_W'(exp1_reg - 1'b1);

    // Stage 2: pick the normalisation case in priority order
    always_comb begin
        exp2_next  = exp1_reg;
        sig2_next  = sig1_reg;
        ovf2_next  = 1'b0;
        tiny2_next = 1'b0;
        zero2_next = 1'b0;
        if (zero1_reg) begin
            exp2_next  = '0;
            sig2_next  = '0;
            zero2_next = 1'b1;
        end else if (carry1_reg) begin
            if (exp_inc >= EXP_TOP) begin
                exp2_next = EXP_TOP[EXP_W-1:0];
                sig2_next = '0;
                ovf2_next = 1'b1;
            end else begin
                exp2_next = exp_inc[EXP_W-1:0];
                // Keep the shifted-out bit alive in the sticky position
                sig2_next = {1'b0, sig1_reg[SIG_W-1:2], sig1_reg[1] | sig1_reg[0]};
            end
        end else if (exp1_reg == '0) begin
            tiny2_next = 1'b1;
        end else if (lzc_ext < exp_ext) begin
            sig2_next = sig1_reg << lzc1_reg;
            exp2_next = EXP_W'(exp_ext - lzc_ext);
        end else begin
            sig2_next  = sig1_reg << tiny_shift;
            exp2_next  = '0;
            tiny2_next = 1'b1;
        end
    end

    // Stage 2: output register, holds while downstream stalls
    always_ff @(posedge clk) begin
        if (rst) begin
            v2_reg    <= 1'b0;
            exp2_reg  <= '0;
            sig2_reg  <= '0;
            ovf2_reg  <= 1'b0;
            tiny2_reg <= 1'b0;
            zero2_reg <= 1'b0;
        end else if (adv2) begin
            v2_reg <= v1_reg;
            if (v1_reg) begin
                exp2_reg  <= exp2_next;
                sig2_reg  <= sig2_next;
                ovf2_reg  <= ovf2_next;
                tiny2_reg <= tiny2_next;
                zero2_reg <= zero2_next;
            end
        end
    end

    assign out_valid = v2_reg;
    assign out_exp   = exp2_reg;
    assign out_sig   = sig2_reg;
    assign out_ovf   = ovf2_reg;
    assign out_tiny  = tiny2_reg;
    assign out_zero  = zero2_reg;

endmodule

// File: tb/tb_fp_norm_exp_adj.sv
// Bench for the post-add normaliser: directed cases, backpressure, reset
// flush and a randomised run against a behavioural normalisation model.
module tb_fp_norm_exp_adj;
    import fp_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [10:0] in_exp;
    logic [56:0] in_sig;
    logic        out_valid;
    logic        out_ready;
    logic [10:0] out_exp;
    logic [56:0] out_sig;
    logic        out_ovf;
    logic        out_tiny;
    logic        out_zero;

    int tests = 0;
    int fails = 0;
    bit rand_ready = 1'b0;

    typedef struct {
        logic [10:0] e;
        logic [56:0] s;
        logic        ovf;
        logic        tiny;
        logic        zero;
    } res_t;

    res_t q[$];

    always #5 clk = ~clk;

    fp_norm_exp_adj dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_exp    (in_exp),
        .in_sig    (in_sig),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_exp   (out_exp),
        .out_sig   (out_sig),
        .out_ovf   (out_ovf),
        .out_tiny  (out_tiny),
        .out_zero  (out_zero)
    );

    // Reference: shift left one place at a time until the hidden bit is set
    // or the exponent bottoms out at 1 (then the value is denormal).
    function automatic res_t model(input logic [10:0] e_in, input logic [56:0] s_in);
        res_t        r;
        int          e;
        logic [56:0] s;
        r.e = '0; r.s = '0; r.ovf = 1'b0; r.tiny = 1'b0; r.zero = 1'b0;
        e = int'(e_in);
        s = s_in;
        if (s == 57'd0) begin
            r.zero = 1'b1;
        end else if (s[56]) begin
            e = e + 1;
            if (e >= EXP_MAX) begin
                r.e   = 11'h7ff;
                r.ovf = 1'b1;
            end else begin
                r.e = 11'(e);
                r.s = (s >> 1) | (s & 57'd1);
            end
        end else if (e == 0) begin
            r.s    = s;
            r.tiny = 1'b1;
        end else begin
            while (!s[55] && e > 1) begin
                s = s << 1;
                e = e - 1;
            end
            r.s = s;
            if (s[55]) r.e = 11'(e);
            else r.tiny = 1'b1;
        end
        return r;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // One clock cycle: sample handshake/outputs before the edge, then score
    task automatic tick(output logic accepted);
        logic        acc_out, hold;
        logic [10:0] pe, ie;
        logic [56:0] ps, is;
        logic        po, pt, pz;
        res_t        r;
        if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
        #1;
        accepted = in_valid & in_ready;
        acc_out  = out_valid & out_ready;
        hold     = out_valid & ~out_ready;
        ie = in_exp;  is = in_sig;
        pe = out_exp; ps = out_sig; po = out_ovf; pt = out_tiny; pz = out_zero;
        @(posedge clk);
        #1;
        if (acc_out) begin
            tests++;
            assert (q.size() != 0) else begin
                fails++;
                $error("FAIL spurious_beat: observed=out_valid expected=no beat pending");
            end
            if (q.size() != 0) begin
                r = q.pop_front();
                chk("out_exp",  64'(pe), 64'(r.e));
                chk("out_sig",  64'(ps), 64'(r.s));
                chk("out_ovf",  64'(po), 64'(r.ovf));
                chk("out_tiny", 64'(pt), 64'(r.tiny));
                chk("out_zero", 64'(pz), 64'(r.zero));
            end
        end
        if (hold) begin
            chk("hold_valid", 64'(out_valid), 64'(1));
            chk("hold_exp",   64'(out_exp),   64'(pe));
            chk("hold_sig",   64'(out_sig),   64'(ps));
        end
        if (accepted) q.push_back(model(ie, is));
    endtask

    task automatic send(input logic [10:0] e, input logic [56:0] s);
        logic a;
        int   n;
        in_valid = 1'b1; in_exp = e; in_sig = s;
        a = 1'b0; n = 0;
        while (!a && n < 100) begin
            tick(a);
            n++;
        end
        tests++;
        assert (a) else begin
            fails++;
            $error("FAIL accept_timeout: observed=not accepted expected=accepted");
        end
        in_valid = 1'b0;
    endtask

    task automatic drain();
        logic a;
        int   n;
        n = 0;
        while (q.size() != 0 && n < 500) begin
            tick(a);
            n++;
        end
        chk("drain_empty", 64'(q.size()), 64'(0));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: observed=still running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        logic        a;
        logic [63:0] r64;
        logic [56:0] s;
        logic [10:0] e;
        int          k;

        rst = 1'b1; in_valid = 1'b0; in_exp = '0; in_sig = '0; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", 64'(out_valid), 64'(0));
        chk("rst_out_exp",   64'(out_exp),   64'(0));
        chk("rst_out_sig",   64'(out_sig),   64'(0));
        chk("rst_flags",     64'({out_ovf, out_tiny, out_zero}), 64'(0));
        rst = 1'b0;
        #1;
        chk("rst_in_ready",  64'(in_ready),  64'(1));
        @(posedge clk);
        #1;

        // 1: carry, with latency observation
        out_ready = 1'b1;
        send(11'd1023, (57'd1 << 56) | 57'd1);
        chk("lat_cycle1_valid", 64'(out_valid), 64'(0));
        tick(a);
        chk("lat_cycle2_valid", 64'(out_valid), 64'(1));
        drain();

        // 2-5: directed cases
        send(11'd1023, 57'd1 << 55);
        send(11'd1023, 57'd1 << 50);
        send(11'd3,    57'd1 << 50);
        send(11'd2046, 57'd1 << 56);
        send(11'd500,  57'd0);
        send(11'd1,    57'd1 << 54);
        send(11'd6,    57'd1 << 50);
        send(11'd5,    57'd1 << 50);
        send(11'd0,    57'd12345);
        drain();

        // 6a: backpressure, three back-to-back beats
        out_ready = 1'b0;
        in_valid = 1'b1; in_exp = 11'd100; in_sig = 57'h0ABCDEF;
        tick(a);
        chk("bp_accept1", 64'(a), 64'(1));
        in_exp = 11'd200; in_sig = 57'd1 << 56;
        tick(a);
        chk("bp_accept2", 64'(a), 64'(1));
        in_exp = 11'd300; in_sig = 57'd7 << 40;
        #1;
        chk("bp_in_ready_low", 64'(in_ready), 64'(0));
        repeat (3) begin
            tick(a);
            chk("bp_stalled", 64'(a), 64'(0));
        end
        out_ready = 1'b1;
        send(11'd300, 57'd7 << 40);
        drain();

        // 6b: reset with two beats in flight
        out_ready = 1'b0;
        send(11'd400, 57'd1 << 30);
        send(11'd401, 57'd1 << 31);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("flush_out_valid", 64'(out_valid), 64'(0));
        chk("flush_out_exp",   64'(out_exp),   64'(0));
        q.delete();
        out_ready = 1'b1;
        repeat (6) tick(a);

        // Randomised run with random backpressure and gaps
        rand_ready = 1'b1;
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 3) == 0) tick(a);
            r64 = {$urandom, $urandom};
            k = int'($urandom_range(0, 5));
            if (k == 0) s = r64[56:0] | (57'd1 << 56);
            else if (k == 1) s = '0;
            else s = r64[56:0] >> $urandom_range(1, 57);
            k = int'($urandom_range(0, 9));
            if (k < 4) e = 11'($urandom_range(1, 2046));
            else if (k < 7) e = 11'($urandom_range(1, 60));
            else if (k < 9) e = 11'($urandom_range(2040, 2046));
            else e = 11'd0;
            send(e, s);
        end
        rand_ready = 1'b0;
        out_ready = 1'b1;
        drain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
